// File: rtl/gemm_pkg.sv
// gemm_pkg: shared widths, array geometry and FSM states for the int8 GEMM engine
package gemm_pkg;
  localparam int InDataWidth   = 8;
  localparam int OutDataWidth  = 32;
  localparam int NumPE_M       = 2;
  localparam int NumPE_N       = 2;
  localparam int NumIp_K       = 16;
  localparam int InMemWidth    = NumPE_M * NumIp_K * InDataWidth;
  localparam int OutMemWidth   = 16 * OutDataWidth;
  localparam int AddrWidth     = 12;
  localparam int SizeAddrWidth = 8;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, WRITE, DONE} state_e;
endpackage

// File: rtl/gemm_pe.sv
// gemm_pe: NumIp_K-wide signed int8 dot product into a wrap-around int32 accumulator
module gemm_pe import gemm_pkg::*; (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic                            clr_i,
  input  logic [NumIp_K*InDataWidth-1:0]  a_i,
  input  logic [NumIp_K*InDataWidth-1:0]  b_i,
  output logic [OutDataWidth-1:0]         acc_o
);
  logic [OutDataWidth-1:0] dot;
  always_comb begin
    dot = '0;
    for (int i = 0; i < NumIp_K; i++)
      dot = dot + OutDataWidth'($signed(a_i[i*InDataWidth +: InDataWidth])) *
                  OutDataWidth'($signed(b_i[i*InDataWidth +: InDataWidth]));
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) acc_o <= '0;
    else if (en_i) acc_o <= clr_i ? dot : acc_o + dot;
endmodule

// File: rtl/gemm_accelerator.sv
// gemm_accelerator: tiled int8 GEMM, streams A/B tiles from SRAM and writes packed int32 C tiles
module gemm_accelerator import gemm_pkg::*; (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  input  logic [InMemWidth-1:0]    sram_a_rdata_i,
  input  logic [InMemWidth-1:0]    sram_b_rdata_i,
  output logic [OutMemWidth-1:0]   sram_c_wdata_o,
  output logic                     sram_c_we_o,
  output logic                     done_o
);
  localparam int KW = NumIp_K * InDataWidth;
  localparam int UsedW = NumPE_M * NumPE_N * OutDataWidth;
  localparam logic [SizeAddrWidth-1:0] One = SizeAddrWidth'(1);
  state_e state, state_n;
  logic [SizeAddrWidth-1:0] k_sz, mt_n, kt_n, nt_n, mt, nt, kt;
  logic [AddrWidth-1:0] a_base, b_base, c_addr;
  logic beat_v, beat_clr, last_kt, last_nt, last_mt, zero_in;
  logic [OutDataWidth-1:0] acc [NumPE_M][NumPE_N];
  assign zero_in = (M_size_i >> $clog2(NumPE_M)) == '0 || (K_size_i >> $clog2(NumIp_K)) == '0 ||
                   (N_size_i >> $clog2(NumPE_N)) == '0;
  assign last_kt = kt == kt_n - One;
  assign last_nt = nt == nt_n - One;
  assign last_mt = mt == mt_n - One;
  assign sram_a_addr_o = a_base + AddrWidth'(kt);
  assign sram_b_addr_o = b_base + AddrWidth'(kt);
  assign sram_c_addr_o = c_addr;
  assign sram_c_we_o = state == WRITE;
  assign done_o = state == DONE;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_i) state_n = zero_in ? DONE : LOAD;
      LOAD:    if (last_kt) state_n = WAIT;
      WAIT:    state_n = WRITE;
      WRITE:   state_n = (last_nt && last_mt) ? DONE : LOAD;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      {k_sz, mt_n, kt_n, nt_n, mt, nt, kt} <= '0;
      {a_base, b_base, c_addr} <= '0;
      {beat_v, beat_clr} <= '0;
    end else begin
      beat_v   <= state == LOAD;
      beat_clr <= state == LOAD && kt == '0;
      case (state)
        IDLE: if (start_i) begin
          k_sz <= K_size_i;
          mt_n <= M_size_i >> $clog2(NumPE_M);
          kt_n <= K_size_i >> $clog2(NumIp_K);
          nt_n <= N_size_i >> $clog2(NumPE_N);
          {mt, nt, kt} <= '0;
          {a_base, b_base, c_addr} <= '0;
        end
        LOAD: kt <= last_kt ? '0 : kt + One;
        WRITE: begin
          c_addr <= c_addr + AddrWidth'(1);
          nt     <= last_nt ? '0 : nt + One;
          b_base <= last_nt ? '0 : b_base + AddrWidth'(k_sz);
          if (last_nt) begin
            mt     <= mt + One;
            a_base <= a_base + AddrWidth'(k_sz);
          end
        end
        default: ;
      endcase
    end
  for (genvar i = 0; i < NumPE_M; i++) begin : g_row
    for (genvar j = 0; j < NumPE_N; j++) begin : g_col
      gemm_pe u_pe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (beat_v),
        .clr_i (beat_clr),
        .a_i   (sram_a_rdata_i[i*KW +: KW]),
        .b_i   (sram_b_rdata_i[j*KW +: KW]),
        .acc_o (acc[i][j])
      );
      assign sram_c_wdata_o[(i*NumPE_N+j)*OutDataWidth +: OutDataWidth] = acc[i][j];
    end
  end
  assign sram_c_wdata_o[OutMemWidth-1:UsedW] = '0;
endmodule

// File: tb/tb_gemm_accelerator.sv
// tb_gemm_accelerator: directed GEMM runs against a reference matrix product
module tb_gemm_accelerator;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] m_sz, k_sz, n_sz;
  logic [11:0] a_addr, b_addr, c_addr;
  logic [255:0] a_rdata, b_rdata;
  logic [511:0] wdata;
  logic we, done;
  logic [255:0] amem [512];
  logic [255:0] bmem [512];
  logic [511:0] cmem [512];
  logic c_clr = 1'b0;
  int wcount = 0;
  int vecs = 0, errs = 0;
  byte a_mat [32][64];
  byte b_mat [32][64];

  gemm_accelerator dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .M_size_i(m_sz), .K_size_i(k_sz), .N_size_i(n_sz),
    .sram_a_addr_o(a_addr), .sram_b_addr_o(b_addr), .sram_c_addr_o(c_addr),
    .sram_a_rdata_i(a_rdata), .sram_b_rdata_i(b_rdata),
    .sram_c_wdata_o(wdata), .sram_c_we_o(we), .done_o(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_rdata <= amem[a_addr[8:0]];
    b_rdata <= bmem[b_addr[8:0]];
    if (c_clr) begin
      for (int i = 0; i < 512; i++) cmem[i] <= {16{32'hdeadbeef}};
    end else if (we) begin
      cmem[c_addr[8:0]] <= wdata;
      wcount <= wcount + 1;
    end
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int m, input int k, input int n, input bit neg);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++) begin
        a_mat[r][c] = neg ? -8'sd128 : byte'($urandom);
        b_mat[r][c] = neg ? -8'sd128 : byte'($urandom);
      end
    for (int t = 0; t < m / 2; t++)
      for (int kt = 0; kt < k / 16; kt++)
        for (int x = 0; x < 2; x++)
          for (int ki = 0; ki < 16; ki++)
            amem[t*k+kt][x*128+ki*8 +: 8] = a_mat[t*2+x][kt*16+ki];
    for (int t = 0; t < n / 2; t++)
      for (int kt = 0; kt < k / 16; kt++)
        for (int x = 0; x < 2; x++)
          for (int ki = 0; ki < 16; ki++)
            bmem[t*k+kt][x*128+ki*8 +: 8] = b_mat[t*2+x][kt*16+ki];
  endtask

  task automatic pulse_start(input int m, input int k, input int n);
    m_sz = 8'(m); k_sz = 8'(k); n_sz = 8'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int m, input int k, input int n);
    int w0, cyc, mt_t, kt_t, nt_t, lat;
    logic [511:0] e;
    mt_t = m / 2; kt_t = k / 16; nt_t = n / 2;
    lat = (mt_t * kt_t * nt_t == 0) ? 1 : mt_t * nt_t * (kt_t + 2) + 1;
    @(negedge clk) c_clr = 1'b1;
    @(negedge clk) c_clr = 1'b0;
    w0 = wcount;
    pulse_start(m, k, n);
    cyc = 1;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("lat_%0dx%0dx%0d", m, k, n), 512'(cyc), 512'(lat));
    @(negedge clk);
    check("done_pulse", 512'(done), '0);
    check($sformatf("writes_%0dx%0dx%0d", m, k, n), 512'(wcount - w0), 512'(mt_t * nt_t));
    for (int mt = 0; mt < mt_t; mt++)
      for (int nt = 0; nt < nt_t; nt++) begin
        e = '0;
        for (int mi = 0; mi < 2; mi++)
          for (int ni = 0; ni < 2; ni++) begin
            int s = 0;
            for (int kk = 0; kk < k; kk++)
              s += int'(a_mat[mt*2+mi][kk]) * int'(b_mat[nt*2+ni][kk]);
            e[(mi*2+ni)*32 +: 32] = s;
          end
        check($sformatf("c%0d", mt*nt_t+nt), cmem[mt*nt_t+nt], e);
      end
  endtask

  initial begin
    int w0;
    m_sz = '0; k_sz = '0; n_sz = '0;
    repeat (2) @(negedge clk);
    check("rst_ctl", 512'({we, done, a_addr, b_addr, c_addr}), '0);
    check("rst_wdata", wdata, '0);
    rst = 1'b0;
    @(negedge clk);
    load(4, 64, 16, 1'b0);
    run(4, 64, 16);
    load(16, 64, 4, 1'b0);
    run(16, 64, 4);
    load(32, 32, 32, 1'b0);
    run(32, 32, 32);
    run(0, 64, 16);
    load(32, 32, 32, 1'b0);
    pulse_start(32, 32, 32);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ctl", 512'({we, done, a_addr, b_addr, c_addr}), '0);
    check("abort_wdata", wdata, '0);
    w0 = wcount;
    repeat (3) @(negedge clk);
    check("abort_writes", 512'(wcount - w0), '0);
    rst = 1'b0;
    @(negedge clk);
    load(2, 16, 2, 1'b1);
    run(2, 16, 2);
    check("neg_c00", 512'(cmem[0][31:0]), 512'(262144));
    check("neg_c11", 512'(cmem[0][127:96]), 512'(262144));
    check("neg_upper", 512'(cmem[0][511:128]), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/gemm_accelerator.md
Name: gemm_accelerator

Overview:
Tiled int8 GEMM engine computing C[M×N] = A[M×K] · B[K×N]^T-packed, with int32 results. It reads packed A and B tiles from two read-only single-port SRAMs (1-cycle read latency) and writes packed int32 C tiles to a third SRAM. It sits between the host's start/size registers and the three SRAM macros. A NumPE_M×NumPE_N array of PEs each reduces NumIp_K products per cycle.

Parameters:
InDataWidth, 8, signed operand width
OutDataWidth, 32, signed accumulator/result width
NumPE_M, 2, PE rows (A rows per tile)
NumPE_N, 2, PE columns (B columns per tile)
NumIp_K, 16, products per PE per cycle (K elements per word)
InMemWidth, NumPE_M*NumIp_K*InDataWidth (256), A/B SRAM word width; A uses NumPE_M rows, B uses NumPE_N columns
OutMemWidth, 16*OutDataWidth (512), C SRAM word width
AddrWidth, 12, SRAM address width
SizeAddrWidth, 8, M/K/N size width

Ports:
clk_i  in  1  clock, all logic rising-edge
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  start pulse, sampled in IDLE only
M_size_i, K_size_i, N_size_i  in  SizeAddrWidth each  matrix dims in elements, latched at start
sram_a_addr_o, sram_b_addr_o, sram_c_addr_o  out  AddrWidth  SRAM addresses
sram_a_rdata_i, sram_b_rdata_i  in  InMemWidth  read data, valid 1 cycle after address
sram_c_wdata_o  out  OutMemWidth  C write data
sram_c_we_o  out  1  C write enable
done_o  out  1  one-cycle completion pulse

Behaviour:
- Tile counts: Mt=M>>log2(NumPE_M), Kt=K>>log2(NumIp_K), Nt=N>>log2(NumPE_N). Sizes must be multiples of the tile dims; remainders are ignored.
- A word at address mt*K+kt: bits [mi*NumIp_K*8+ki*8 +:8] = A[mt*NumPE_M+mi][kt*NumIp_K+ki]. B word at address nt*K+kt uses the same layout with ni in place of mi. Operands are signed two's complement.
- C word at address mt*Nt+nt: bits [(mi*NumPE_N+ni)*32 +:32] = Σk A·B for row mt*NumPE_M+mi, column nt*NumPE_N+ni. Unused upper bits are written 0.
- Loop order: mt outer, nt middle, kt inner.
- Arithmetic: 8×8 signed product sign-extended to 32 bits; adder tree plus accumulator in 32-bit wrap-around.
- FSM states:
  - IDLE: start_i latches sizes → LOAD.
  - LOAD: issues A/B addresses for kt=0..Kt-1 on consecutive cycles. Data returns next cycle; the accumulator clears on the kt=0 data beat and adds on every data beat.
  - WRITE: one cycle after the last beat, sram_c_we_o=1 with addr/data for the tile. Then advance the tile → LOAD, or after the last tile → DONE.
  - DONE: done_o=1 for one cycle → IDLE.
- Latency per tile: Kt+2 cycles.
- If any of Mt, Kt or Nt is 0: IDLE → DONE directly, no C writes.
- start_i is ignored outside IDLE.
- Reset values: all outputs 0, FSM=IDLE, counters and accumulators 0. Reset mid-operation aborts immediately; no further writes occur.
- sram_c_we_o is high only in WRITE.

Decomposition:
- Package gemm_pkg: default width/array constants, FSM state enum.
- Sub-module gemm_pe: NumIp_K-wide signed dot product plus 32-bit accumulator with clear/enable. Instantiate NumPE_M×NumPE_N copies.
- Top holds the FSM, address generators and C packing.
- SRAMs are external behavioural single_port_memory instances (sync write, 1-cycle registered read).

Test Plan:
- M=4,K=64,N=16, random int8 → C addresses 0..15 match golden; done_o after 2·8 tiles × 6 cycles ≈ 96+ cycles.
- M=16,K=64,N=4, random → 16 C words correct; second test without reset between runs.
- M=32,K=32,N=32, random → 256 C words correct.
- All A=-128, all B=-128, M=2,K=16,N=2 → each C element = 262144; upper 384 bits 0.
- M=0 → done_o pulses within 2 cycles of start, sram_c_we_o never asserted.
- Assert rst_i mid-run (M=32,K=32,N=32) → outputs 0 next edge, no writes; fresh start completes correctly.
